// File: rtl/quo_bcd_conv_if.sv
// Start/ready/done_tick handshake and result bus of the binary-to-BCD converter.
// The master issues conversions; the converter is the slave.
interface quo_bcd_conv_if #(
  parameter int W = 32,
  parameter int D = 10
);
  logic           start;
  logic [W-1:0]   bin;
  logic           ready;
  logic           done_tick;
  logic [4*D-1:0] bcd;
  logic           ovf;

  modport master (
    output start, bin,
    input  ready, done_tick, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output ready, done_tick, bcd, ovf
  );
endinterface

// File: rtl/quo_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per cycle.
// Handshake matches the div unit so its done_tick can drive start directly.
module quo_bcd_conv #(
  parameter int W    = 32,
  parameter int D    = 10,
  parameter int CBIT = 6
) (
  input logic           clk,
  input logic           reset,
  quo_bcd_conv_if.slave bus
);
  // state | meaning
  // IDLE  | ready=1; bcd/ovf hold the last result
  // OP    | one adjust-and-shift iteration per cycle, W cycles
  // DONE  | done_tick=1 for one cycle; bcd/ovf final
  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      sreg_q, sreg_d;
  logic [D-1:0][3:0] dig_q, dig_d, adj;
  logic              ovf_q, ovf_d;
  logic [CBIT-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Digits >= 5 are pre-corrected so the following doubling carries in decimal.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      adj[i] = (dig_q[i] >= 4'd5) ? (dig_q[i] + 4'd3) : dig_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    dig_d         = dig_q;
    ovf_d         = ovf_q;
    cnt_d         = cnt_q;
    bus.ready     = 1'b0;
    bus.done_tick = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          sreg_d  = bus.bin;
          dig_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CBIT'(W);
          state_d = OP;
        end
      end
      OP: begin
        dig_d[0] = {adj[0][2:0], sreg_q[W-1]};
        for (int i = 1; i < D; i++) begin
          dig_d[i] = {adj[i][2:0], adj[i-1][3]};
        end
        sreg_d = {sreg_q[W-2:0], 1'b0};
        // Anything carried out of the top digit means the value needs more than D digits.
        ovf_d  = ovf_q | adj[D-1][3];
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q <= CBIT'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done_tick = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bcd = dig_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_quo_bcd_conv.sv
// Randomized self-checking bench for quo_bcd_conv: a 10-digit and a 4-digit
// instance compared against a decimal reference computed with plain arithmetic.
module tb_quo_bcd_conv;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  quo_bcd_conv_if #(.W(W), .D(10)) if10 ();
  quo_bcd_conv_if #(.W(W), .D(4))  if4 ();

  quo_bcd_conv #(.W(W), .D(10), .CBIT(6)) u_dut10 (
    .clk   (clk),
    .reset (reset),
    .bus   (if10.slave)
  );

  quo_bcd_conv #(.W(W), .D(4), .CBIT(6)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal digits of v, units first, truncated to d digits.
  function automatic logic [39:0] ref_bcd(input longint unsigned v, input int d);
    logic [39:0]     r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return (v >= p);
  endfunction

  function automatic logic get_rdy(input int s);
    return (s == 4) ? if4.ready : if10.ready;
  endfunction

  function automatic logic get_done(input int s);
    return (s == 4) ? if4.done_tick : if10.done_tick;
  endfunction

  function automatic logic get_ovf(input int s);
    return (s == 4) ? if4.ovf : if10.ovf;
  endfunction

  function automatic logic [39:0] get_bcd(input int s);
    return (s == 4) ? {24'd0, if4.bcd} : if10.bcd;
  endfunction

  task automatic drive(input int s, input logic st, input logic [31:0] v);
    if (s == 4) begin
      if4.start = st;
      if4.bin   = v;
    end else begin
      if10.start = st;
      if10.bin   = v;
    end
  endtask

  // One conversion on instance s (10 or 4 digits). pulse_at>0 raises start with
  // bin=5 for a single cycle that many cycles after the accept edge.
  task automatic conv(input int s, input logic [31:0] v, input int pulse_at);
    int          n;
    int          wn;
    int          rdy_hi;
    bit          seen;
    logic [39:0] eb;
    logic        eo;
    n      = 0;
    wn     = 0;
    rdy_hi = 0;
    seen   = 1'b0;
    eb     = ref_bcd(longint'(v), s);
    eo     = ref_ovf(longint'(v), s);
    while (!get_rdy(s) && wn < 100) begin
      @(negedge clk);
      wn++;
    end
    check("idle_ready", 64'(get_rdy(s)), 64'd1);
    drive(s, 1'b1, v);
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      drive(s, (n == pulse_at), (n == pulse_at) ? 32'd5 : $urandom);
      if (get_rdy(s)) rdy_hi++;
      if (get_done(s)) seen = 1'b1;
    end
    check("latency", 64'(n), 64'(W + 1));
    check("ready_low", 64'(rdy_hi), 64'd0);
    check("bcd", 64'(get_bcd(s)), 64'(eb));
    check("ovf", 64'(get_ovf(s)), 64'(eo));
    @(negedge clk);
    drive(s, 1'b0, $urandom);
    check("ready_back", 64'(get_rdy(s)), 64'd1);
    check("done_single", 64'(get_done(s)), 64'd0);
    repeat (2) @(negedge clk);
    check("bcd_hold", 64'(get_bcd(s)), 64'(eb));
    check("ovf_hold", 64'(get_ovf(s)), 64'(eo));
    check("ready_hold", 64'(get_rdy(s)), 64'd1);
  endtask

  initial begin
    logic [31:0] quo;
    logic [31:0] rmd;
    bit          seen;

    reset = 1'b1;
    drive(10, 1'b0, 32'd0);
    drive(4, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    for (int s = 4; s <= 10; s += 6) begin
      check("rst_ready", 64'(get_rdy(s)), 64'd1);
      check("rst_done", 64'(get_done(s)), 64'd0);
      check("rst_bcd", 64'(get_bcd(s)), 64'd0);
      check("rst_ovf", 64'(get_ovf(s)), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    conv(10, 32'd0, 0);
    conv(10, 32'hFFFF_FFFF, 0);
    conv(10, 32'd1234567890, 0);
    conv(10, 32'd42, 5);
    conv(10, 32'd5, 0);
    conv(10, 32'd77, W + 1);

    conv(4, 32'd10000, 0);
    conv(4, 32'd9999, 0);
    for (int i = 0; i < 15; i++) conv(4, $urandom_range(0, 99999), 0);
    for (int i = 0; i < 20; i++) conv(10, $urandom >> $urandom_range(0, 31), $urandom_range(0, 40));
    conv(4, 32'd12345, 0);

    // Abort in the 10th OP cycle; the 4-digit instance still holds 2345/ovf.
    drive(10, 1'b1, 32'hFFFF_FFFF);
    seen = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) drive(10, 1'b0, 32'd0);
      if (if10.done_tick) seen = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 64'(if10.ready), 64'd1);
    check("abort_bcd", 64'(if10.bcd), 64'd0);
    check("abort_ovf", 64'(if10.ovf), 64'd0);
    check("abort_bcd4", 64'(if4.bcd), 64'd0);
    check("abort_ovf4", 64'(if4.ovf), 64'd0);
    for (int n = 0; n < 40; n++) begin
      if (if10.done_tick) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 64'(seen), 64'd0);
    conv(10, 32'd907, 0);

    // Upstream divider result 1000/7 handed over as if from its done_tick.
    quo = 32'd1000 / 32'd7;
    rmd = 32'd1000 % 32'd7;
    conv(10, quo, 0);
    conv(10, rmd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
